// File: rtl/lab6_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lab6_pkg
//  Purpose  : Shared types and defaults for the instruction loader front-end:
//             loader FSM state encoding, default debounce/sync depths and a
//             byte-lane merge helper for the instruction register.
//  Revision : 1.0 - initial release
// ============================================================================
package lab6_pkg;

    // Loader sequencing states; IDLE is the only state that accepts key events.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    // 10 ms of stability at 50 MHz before a key change is believed.
    localparam int DEF_DEBOUNCE = 500000;

    // Two flops is the minimum for a metastability-safe synchroniser.
    localparam int DEF_SYNC = 2;

    // Replace one byte lane of the instruction word, keeping the other lane.
    function automatic logic [15:0] lane_merge(
        input logic [15:0] cur,
        input logic [7:0]  data,
        input logic        hi_lane
    );
        return hi_lane ? {data, cur[7:0]} : {cur[15:8], data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader_if
//  Purpose  : Board-side bundle of the instruction loader: switches and raw
//             keys in, cpu handshake and display signals out. The loader
//             itself takes the slave view; whatever drives the board pins
//             (top-level wrapper or a bench) takes the master view.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_loader_if;

    logic [9:0]  sw;           // sw[9] = lane select, sw[7:0] = data byte
    logic        enter_n;      // raw active-low "latch byte" key
    logic        go_n;         // raw active-low "execute" key
    logic        w;            // cpu idle/wait flag
    logic [15:0] ir;           // assembled instruction word
    logic        load;         // one-cycle load strobe to the cpu
    logic        s;            // cpu start request
    logic        busy;         // loader is sequencing
    logic [7:0]  ledr;         // shows the lane not currently selected
    logic [7:0]  instr_count;  // completed instructions, modulo 256

    modport master (
        output sw, enter_n, go_n, w,
        input  ir, load, s, busy, ledr, instr_count
    );

    modport slave (
        input  sw, enter_n, go_n, w,
        output ir, load, s, busy, ledr, instr_count
    );

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Conditions one raw active-low push-button: synchronises it into
//             clk, requires DEBOUNCE_CYCLES consecutive disagreeing samples
//             before accepting a new level, and emits a one-cycle pulse on
//             each accepted press (released -> pressed). Releases are silent.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import lab6_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int SYNC_STAGES     = DEF_SYNC
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic key_n,
    output logic      pressed,
    output logic      press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int                 c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   db_q;      // debounced level, 1 = released
    logic                   db_d;
    logic [c_cnt_w-1:0]     cnt_q;
    logic [c_cnt_w-1:0]     cnt_d;
    logic                   press_q;
    logic                   press_d;
    logic                   w_synced;

    // Shift chain: new raw sample enters at bit 0, the oldest sits at the top.
    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
            end
        end else begin : g_sync_single
            always_comb begin
                sync_d = key_n;
            end
        end
    endgenerate

    assign w_synced = sync_q[SYNC_STAGES-1];

    // Stability counter: any agreement restarts the count; the level flips
    // only after a full run of disagreeing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (w_synced != db_q) begin
            if (cnt_q == c_cnt_max) begin
                db_d  = w_synced;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
        // Pulse only on the accepted falling edge of the active-low key.
        press_d = db_q & ~db_d;
    end

    // State registers; reset treats the key as released everywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign pressed = ~db_q;
    assign press   = press_q;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Upstream front-end for the cpu. Debounces the ENTER and GO keys,
//             assembles the 16-bit instruction a byte lane at a time from the
//             switches, then runs the cpu load/start handshake and waits for
//             the cpu to return to its wait state before counting the
//             instruction as completed.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_loader
    import lab6_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int SYNC_STAGES     = DEF_SYNC
) (
    input  wire logic      clk,
    input  wire logic      reset,
    instr_loader_if.slave  bus
);

    logic          w_enter_press;
    logic          w_go_press;
    logic          w_enter_pressed;
    logic          w_go_pressed;
    logic          w_unused_levels;

    loader_state_t state_q;
    logic [15:0]   ir_q;
    logic          load_q;
    logic          s_q;
    logic          busy_q;
    logic [7:0]    count_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_enter_db (
        .clk     (clk),
        .reset   (reset),
        .key_n   (bus.enter_n),
        .pressed (w_enter_pressed),
        .press   (w_enter_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_go_db (
        .clk     (clk),
        .reset   (reset),
        .key_n   (bus.go_n),
        .pressed (w_go_pressed),
        .press   (w_go_press)
    );

    // Held levels and sw[8] have no role in sequencing; gathered here only.
    assign w_unused_levels = w_enter_pressed ^ w_go_pressed ^ bus.sw[8];

    // Loader sequencer. Outputs are registered and set on the transition into
    // the state that owns them, so load and s are glitch-free and disjoint.
    // Key events outside IDLE fall through untouched and are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
            load_q  <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // ENTER has priority; a coincident GO is dropped.
                    if (w_enter_press) begin
                        ir_q <= lane_merge(ir_q, bus.sw[7:0], bus.sw[9]);
                    end else if (w_go_press) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    s_q     <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    // cpu leaving its wait state acknowledges the request.
                    if (!bus.w) begin
                        s_q     <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Count lands as DONE is entered, a cycle before busy drops.
                    if (bus.w) begin
                        count_q <= count_q + 8'd1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    load_q  <= 1'b0;
                    s_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir          = ir_q;
    assign bus.load        = load_q;
    assign bus.s           = s_q;
    assign bus.busy        = busy_q;
    assign bus.instr_count = count_q;
    assign bus.ledr        = bus.sw[9] ? ir_q[7:0] : ir_q[15:8];

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Purpose  : Directed self-checking bench for instr_loader with a short
//             debounce window (4 cycles) and a 2-stage synchroniser.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_loader_if bus ();

    instr_loader #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (bus.ir !== 16'h0000) begin failures++; $display("FAIL reset_ir actual=%h required=%h", bus.ir, 16'h0000); end
        checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL reset_load actual=%b required=0", bus.load); end
        checks++; if (bus.s !== 1'b0) begin failures++; $display("FAIL reset_s actual=%b required=0", bus.s); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.instr_count !== 8'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", bus.instr_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_byte_lane();
        int first_k;
        first_k = -1;
        bus.sw = 10'h2AB;
        bus.enter_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (u_dut.w_enter_press === 1'b1 && first_k < 0) first_k = k;
        end
        bus.enter_n = 1'b1;
        repeat (10) tick();
        checks++; if (first_k !== 6) begin failures++; $display("FAIL press_latency actual=%0d required=6", first_k); end
        checks++; if (bus.ir !== 16'hAB00) begin failures++; $display("FAIL lane_hi actual=%h required=%h", bus.ir, 16'hAB00); end
        bus.sw = 10'h0CD;
        bus.enter_n = 1'b0;
        repeat (10) tick();
        bus.enter_n = 1'b1;
        repeat (10) tick();
        checks++; if (bus.ir !== 16'hABCD) begin failures++; $display("FAIL lane_lo actual=%h required=%h", bus.ir, 16'hABCD); end
        checks++; if (bus.ledr !== 8'hAB) begin failures++; $display("FAIL ledr_sw9_0 actual=%h required=%h", bus.ledr, 8'hAB); end
        bus.sw = 10'h200;
        #1;
        checks++; if (bus.ledr !== 8'hCD) begin failures++; $display("FAIL ledr_sw9_1 actual=%h required=%h", bus.ledr, 8'hCD); end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        bus.sw = 10'h011;
        for (int k = 0; k < 30; k++) begin
            bus.enter_n = (k < 20) ? ((k / 2) % 2 == 1) : 1'b1;
            tick();
            if (u_dut.w_enter_press === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL bounce_pulses actual=%0d required=0", pulses); end
        checks++; if (bus.ir !== 16'hABCD) begin failures++; $display("FAIL bounce_ir actual=%h required=%h", bus.ir, 16'hABCD); end
    endtask

    // GO pressed right after edge 0: press pulse after edge 6, load after 7,
    // s after 8..10 (cpu drops w after 10), RUN until w returns after 15,
    // count bumps after 16, busy clears after 17.
    task automatic run_handshake(input string tag, input bit enter_in_run,
                                 input logic [7:0] count_before);
        int          s_k;
        logic        exp_load;
        logic        exp_s;
        logic        exp_busy;
        logic [7:0]  exp_cnt;
        s_k = -1;
        bus.w = 1'b1;
        bus.go_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_load = (k == 7);
            exp_s    = (k >= 8 && k <= 10);
            exp_busy = (k >= 7 && k <= 16);
            exp_cnt  = (k >= 16) ? count_before + 8'd1 : count_before;
            checks++; if (bus.load !== exp_load) begin failures++; $display("FAIL %s_load k=%0d actual=%b required=%b", tag, k, bus.load, exp_load); end
            checks++; if (bus.s !== exp_s) begin failures++; $display("FAIL %s_s k=%0d actual=%b required=%b", tag, k, bus.s, exp_s); end
            checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL %s_busy k=%0d actual=%b required=%b", tag, k, bus.busy, exp_busy); end
            checks++; if (bus.instr_count !== exp_cnt) begin failures++; $display("FAIL %s_count k=%0d actual=%0d required=%0d", tag, k, bus.instr_count, exp_cnt); end
            // cpu model: leave wait 2 cycles after seeing s, return 5 later
            if (bus.s === 1'b1 && s_k < 0) s_k = k;
            if (s_k > 0 && k == s_k + 2) bus.w = 1'b0;
            if (s_k > 0 && k == s_k + 7) bus.w = 1'b1;
            if (k == 10) bus.go_n = 1'b1;
            if (enter_in_run && k == 6) begin
                bus.sw = 10'h2FF;
                bus.enter_n = 1'b0;
            end
            if (k == 16) bus.enter_n = 1'b1;
        end
        bus.w = 1'b1;
        checks++; if (bus.ir !== 16'hABCD) begin failures++; $display("FAIL %s_ir actual=%h required=%h", tag, bus.ir, 16'hABCD); end
    endtask

    task automatic test_handshake();
        run_handshake("hs", 1'b0, 8'd0);
    endtask

    task automatic test_busy_events();
        run_handshake("busy_ev", 1'b1, 8'd1);
    endtask

    task automatic test_simultaneous();
        int ek;
        int gk;
        bit load_seen;
        bit busy_seen;
        ek = -1; gk = -1; load_seen = 1'b0; busy_seen = 1'b0;
        bus.sw = 10'h211;
        bus.enter_n = 1'b0;
        bus.go_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (u_dut.w_enter_press === 1'b1 && ek < 0) ek = k;
            if (u_dut.w_go_press === 1'b1 && gk < 0) gk = k;
            if (bus.load !== 1'b0) load_seen = 1'b1;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
            if (k == 10) begin
                bus.enter_n = 1'b1;
                bus.go_n = 1'b1;
            end
        end
        checks++; if (ek !== 6 || gk !== 6) begin failures++; $display("FAIL simul_pulses actual=enter@%0d,go@%0d required=both@6", ek, gk); end
        checks++; if (bus.ir !== 16'h11CD) begin failures++; $display("FAIL simul_ir actual=%h required=%h", bus.ir, 16'h11CD); end
        checks++; if (load_seen !== 1'b0) begin failures++; $display("FAIL simul_load actual=%b required=0", load_seen); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL simul_busy actual=%b required=0", busy_seen); end
    endtask

    task automatic test_reset_mid();
        bus.w = 1'b1;
        bus.go_n = 1'b0;
        repeat (8) tick();
        checks++; if (bus.s !== 1'b1) begin failures++; $display("FAIL rst_mid_in_start actual=%b required=1", bus.s); end
        reset = 1'b1;
        bus.go_n = 1'b1;
        tick();
        checks++; if (bus.s !== 1'b0) begin failures++; $display("FAIL rst_mid_s actual=%b required=0", bus.s); end
        checks++; if (bus.ir !== 16'h0000) begin failures++; $display("FAIL rst_mid_ir actual=%h required=%h", bus.ir, 16'h0000); end
        checks++; if (bus.instr_count !== 8'd0) begin failures++; $display("FAIL rst_mid_count actual=%0d required=0", bus.instr_count); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.load !== 1'b0) begin failures++; $display("FAIL rst_mid_load actual=%b required=0", bus.load); end
        reset = 1'b0;
        repeat (20) tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_restart actual=%b required=0", bus.busy); end
        checks++; if (bus.instr_count !== 8'd0) begin failures++; $display("FAIL rst_mid_nocount actual=%0d required=0", bus.instr_count); end
    endtask

    // One quick instruction with a cpu that answers immediately (w = !s).
    task automatic one_instr();
        bus.go_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            bus.w = ~bus.s;
            if (k == 8) bus.go_n = 1'b1;
        end
        bus.w = 1'b1;
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 255; n++) one_instr();
        checks++; if (bus.instr_count !== 8'd255) begin failures++; $display("FAIL wrap_255 actual=%0d required=255", bus.instr_count); end
        one_instr();
        checks++; if (bus.instr_count !== 8'd0) begin failures++; $display("FAIL wrap_0 actual=%0d required=0", bus.instr_count); end
    endtask

    initial begin
        reset = 1'b1;
        bus.sw = '0;
        bus.enter_n = 1'b1;
        bus.go_n = 1'b1;
        bus.w = 1'b1;
        test_reset();
        test_byte_lane();
        test_bounce();
        test_handshake();
        test_busy_events();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream front-end for the `cpu` on the DE1-SoC board.
- Conditions raw push-button inputs by synchronising and debouncing them.
- Assembles the 16-bit instruction word from SW[7:0] one byte lane at a time.
- Sequences the cpu `load`/`s` handshake, then waits on `w` for completion. This replaces manual KEY3/KEY2 timing and the free-running switch register.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key change is accepted (10 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages in each key synchroniser (minimum 2).

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  synchronous, active-high reset.
- sw  input  10  board switches; sw[9] selects the byte lane, sw[7:0] is the data byte.
- enter_n  input  1  raw active-low key; a press latches sw[7:0] into the selected lane of ir.
- go_n  input  1  raw active-low key; a press starts the load/execute sequence.
- w  input  1  cpu wait flag; 1 means the cpu is idle in its wait state.
- ir  output  16  instruction word to cpu `in`.
- load  output  1  one-cycle pulse to cpu `load`.
- s  output  1  cpu start request.
- busy  output  1  high whenever state is not IDLE.
- ledr  output  8  shows the opposite lane: sw[9] ? ir[7:0] : ir[15:8] (combinational).
- instr_count  output  8  count of instructions completed; wraps at 255 to 0.

Behaviour:
- Reset values: ir=0, load=0, s=0, busy=0, instr_count=0, state=IDLE.
- Reset forces all synchroniser flops to "released" (1) and all debounce counters to 0.
- Reset asserted mid-sequence aborts immediately; there is no completion pulse and no count increment.
- Debounce, per key:
  - Raw input passes through SYNC_STAGES flops.
  - The counter increments each cycle the synced value differs from the debounced value, and clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the debounced value flips and the counter clears.
  - A press event is a one-cycle pulse on the debounced 1->0 transition. Releases produce no event.
  - Latency from a stable raw low level to the press pulse is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, LOAD, START, RUN, DONE.
  - IDLE, enter event: ir[15:8]<=sw[7:0] if sw[9]=1, else ir[7:0]<=sw[7:0]. The other lane is unchanged and the state stays IDLE.
  - IDLE, go event (no enter event in the same cycle): go to LOAD.
  - IDLE, enter and go events in the same cycle: enter wins, the byte is latched and go is dropped.
  - LOAD: load=1 for exactly this cycle, then go to START.
  - START: s=1. Hold s until w==0 is sampled, then go to RUN with s=0 on the next cycle. If w stays 1, s stays high indefinitely.
  - RUN: s=0. Wait until w==1, then go to DONE.
  - DONE: instr_count<=instr_count+1 (mod 256) for one cycle, then go to IDLE.
- Key events arriving in any state other than IDLE are discarded, never queued.
- ir is stable from LOAD through DONE.
- load and s are registered outputs, never asserted together, and are glitch-free.
- busy=1 in LOAD, START, RUN and DONE.

Decomposition:
- Package lab6_pkg holds:
  - the loader_state_t enum {IDLE, LOAD, START, RUN, DONE};
  - the localparams DEF_DEBOUNCE=500000 and DEF_SYNC=2.
- Sub-module key_debounce (parameters DEBOUNCE_CYCLES, SYNC_STAGES):
  - ports clk, reset, key_n, pressed (level), press (pulse);
  - instantiated twice, once for enter_n and once for go_n.
- The FSM, ir register and counter live in instr_loader itself.

Test Plan (simulation uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Byte lane entry: sw=10'h2_AB, hold enter_n=0 for 10 cycles and release; then sw=10'h0_CD with the same press. Expect ir=16'hABCD; ledr=8'hAB while sw[9]=0. The first press pulse appears exactly 6 cycles after enter_n falls.
- Bounce rejection: toggle enter_n low/high every 2 cycles for 20 cycles, then hold high. Expect no press pulse and ir unchanged.
- Full handshake with a cpu model that drops w 2 cycles after sampling s=1 and raises w 5 cycles later:
  - go press leads to load high for 1 cycle, then s high in the next cycle until w falls;
  - busy is high throughout;
  - instr_count goes 0->1 once w returns to 1, and busy falls 1 cycle later.
- Events while busy: an enter press with sw=10'h2_FF during RUN leaves ir unchanged and causes no extra load pulse.
- Simultaneous events: force enter and go press pulses in the same IDLE cycle. Expect the byte latched, state stays IDLE, and load stays 0.
- Reset and wrap:
  - assert reset during START: expect s=0, ir=0, instr_count=0 and IDLE on the next edge;
  - separately, preload 255 completions: expect instr_count to wrap to 0.
